apb_reg_arbiter: RTL and testbench

Two-port APB master and arbiter that shares the bridge's APB configuration register slave between two requesters: the AXI-side bridge control path (port 0) and a debug/boot-config port (port 1). It accepts simple valid/ready commands, arbitrates round-robin, and runs one APB transfer at a time (SETUP, then ACCESS with wait states). It returns read data and error status to the winning requester, and aborts with an error if the slave stalls past a timeout.

---
 rtl/apb_reg_arbiter.sv | 145 ++++++++++++++
 tb/tb_apb_reg_arbiter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/apb_reg_arbiter.sv
// rtl/apb_reg_arbiter.sv - two-requester round-robin APB master with wait-state timeout
module apb_reg_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                pclk,
  input  logic                preset_n,
  input  logic [1:0]          req_valid,
  input  logic [1:0]          req_write,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  input  logic [7:0]          req_strb,
  input  logic [5:0]          req_prot,
  output logic [1:0]          req_ready,
  output logic [1:0]          rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                psel,
  output logic                penable,
  output logic                pwrite,
  output logic [ADDR_W-1:0]   paddr,
  output logic [DATA_W-1:0]   pwdata,
  output logic [3:0]          pstrb,
  output logic [2:0]          pprot,
  input  logic                pready,
  input  logic                pslverr,
  input  logic [DATA_W-1:0]   prdata
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  state_e              state_q, state_d;
  logic                ptr_q, ptr_d;
  logic                owner_q, owner_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic [3:0]          pstrb_q, pstrb_d;
  logic [2:0]          pprot_q, pprot_d;
  logic [1:0]          rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic                gnt_idx;

  // ptr_q holds the last granted requester; the other one wins a tie
  always_comb begin
    if (&req_valid) gnt_idx = ~ptr_q;
    else            gnt_idx = req_valid[1];
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pstrb_d     = pstrb_q;
    pprot_d     = pprot_q;
    rsp_valid_d = 2'b00;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    req_ready   = 2'b00;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          req_ready = gnt_idx ? 2'b10 : 2'b01;
          ptr_d     = gnt_idx;
          owner_d   = gnt_idx;
          pwrite_d  = req_write[gnt_idx];
          paddr_d   = gnt_idx ? req_addr[2*ADDR_W-1:ADDR_W]  : req_addr[ADDR_W-1:0];
          pwdata_d  = gnt_idx ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
          pstrb_d   = gnt_idx ? req_strb[7:4] : req_strb[3:0];
          pprot_d   = gnt_idx ? req_prot[5:3] : req_prot[2:0];
          cnt_d     = '0;
          state_d   = SETUP;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        cnt_d = cnt_q + CW'(1);
        if (pready) begin
          rsp_valid_d = owner_q ? 2'b10 : 2'b01;
          rsp_rdata_d = pwrite_q ? '0 : prdata;
          rsp_err_d   = pslverr;
          state_d     = IDLE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          // this is the TIMEOUT-th stalled ACCESS cycle
          rsp_valid_d = owner_q ? 2'b10 : 2'b01;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b1;
      owner_q     <= 1'b0;
      cnt_q       <= '0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      pprot_q     <= '0;
      rsp_valid_q <= 2'b00;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      pprot_q     <= pprot_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign psel      = (state_q == SETUP) || (state_q == ACCESS);
  assign penable   = (state_q == ACCESS);
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign pstrb     = pstrb_q;
  assign pprot     = pprot_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_reg_arbiter.sv
// tb/tb_apb_reg_arbiter.sv - directed self-checking bench for apb_reg_arbiter
module tb_apb_reg_arbiter;

  logic        pclk = 1'b0;
  logic        preset_n;
  logic [1:0]  req_valid, req_write;
  logic [63:0] req_addr, req_wdata;
  logic [7:0]  req_strb;
  logic [5:0]  req_prot;
  logic [1:0]  req_ready, rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err, psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic        pready, pslverr;
  logic [31:0] prdata;

  int checks = 0;
  int passes = 0;

  apb_reg_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .pclk(pclk), .preset_n(preset_n),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_strb(req_strb), .req_prot(req_prot),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .pready(pready), .pslverr(pslverr), .prdata(prdata)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    preset_n = 1'b0; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    req_strb = '0; req_prot = '0; pready = 1'b0; pslverr = 1'b0; prdata = '0;
    repeat (2) @(negedge pclk);
    chk("rst_psel_pen", {psel, penable}, 2'b00);
    chk("rst_rsp_valid", rsp_valid, 2'b00);
    chk("rst_req_ready", req_ready, 2'b00);
    chk("rst_paddr", paddr, 32'h0);
    chk("rst_rsp", {rsp_err, rsp_rdata}, 33'h0);
    @(negedge pclk); preset_n = 1'b1;
    @(negedge pclk);

    // contention: both valid, grants alternate starting with requester 0
    req_valid = 2'b11; req_write = 2'b00; req_addr = {32'h20, 32'h10}; pready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      prdata = 32'hA0 + k;
      #1;
      chk("cont_grant", req_ready, (k % 2) ? 2'b10 : 2'b01);
      if (k > 0) begin
        chk("cont_rsp_valid", rsp_valid, (k % 2) ? 2'b01 : 2'b10);
        chk("cont_rsp_rdata", rsp_rdata, 32'hA0 + k - 1);
      end
      @(negedge pclk);
      chk("cont_setup", {psel, penable}, 2'b10);
      chk("cont_paddr_setup", paddr, (k % 2) ? 32'h20 : 32'h10);
      @(negedge pclk);
      chk("cont_access", {psel, penable}, 2'b11);
      chk("cont_paddr_access", paddr, (k % 2) ? 32'h20 : 32'h10);
      @(negedge pclk);
    end
    req_valid = 2'b00; #1;
    chk("cont_last_rsp", rsp_valid, 2'b10);
    chk("cont_last_rdata", rsp_rdata, 32'hA3);
    chk("cont_no_grant", req_ready, 2'b00);

    // single read from requester 0
    @(negedge pclk);
    req_valid = 2'b01; req_addr[31:0] = 32'h04; prdata = 32'h0000_1FFF; #1;
    chk("rd_grant", req_ready, 2'b01);
    @(negedge pclk); req_valid = 2'b00;
    chk("rd_setup", {psel, penable, pwrite}, 3'b100);
    chk("rd_paddr", paddr, 32'h04);
    chk("rd_ready_low", req_ready, 2'b00);
    @(negedge pclk);
    chk("rd_access", {psel, penable}, 2'b11);
    @(negedge pclk);
    chk("rd_rsp_valid", rsp_valid, 2'b01);
    chk("rd_rsp", {rsp_err, rsp_rdata}, {1'b0, 32'h0000_1FFF});
    chk("rd_psel_off", {psel, penable}, 2'b00);

    // slave error on a requester-1 write
    req_valid = 2'b10; req_write = 2'b10; req_addr[63:32] = 32'h08;
    req_wdata[63:32] = 32'hDEAD_BEEF; req_strb[7:4] = 4'hF; req_prot[5:3] = 3'b010;
    pslverr = 1'b1; prdata = 32'h5555; #1;
    chk("err_grant", req_ready, 2'b10);
    @(negedge pclk); req_valid = 2'b00;
    chk("err_pwrite", pwrite, 1'b1);
    chk("err_pwdata", pwdata, 32'hDEAD_BEEF);
    chk("err_paddr", paddr, 32'h08);
    chk("err_strb_prot", {pstrb, pprot}, {4'hF, 3'b010});
    @(negedge pclk);
    chk("err_access", {psel, penable}, 2'b11);
    @(negedge pclk);
    chk("err_rsp_valid", rsp_valid, 2'b10);
    chk("err_rsp", {rsp_err, rsp_rdata}, {1'b1, 32'h0});
    pslverr = 1'b0; req_write = 2'b00;

    // two wait states then pready
    req_valid = 2'b01; req_addr[31:0] = 32'h0C; pready = 1'b0; #1;
    chk("ws_grant", req_ready, 2'b01);
    @(negedge pclk); req_valid = 2'b00;
    @(negedge pclk);
    chk("ws_acc1", {psel, penable}, 2'b11);
    chk("ws_paddr1", paddr, 32'h0C);
    @(negedge pclk);
    chk("ws_acc2", {psel, penable}, 2'b11);
    chk("ws_no_rsp", rsp_valid, 2'b00);
    @(negedge pclk);
    pready = 1'b1; prdata = 32'h1234;
    chk("ws_acc3", {psel, penable, pwrite}, 3'b110);
    chk("ws_paddr3", paddr, 32'h0C);
    @(negedge pclk);
    chk("ws_rsp_valid", rsp_valid, 2'b01);
    chk("ws_rdata", rsp_rdata, 32'h1234);
    chk("ws_psel_off", psel, 1'b0);

    // timeout with TIMEOUT=4, then a normal grant
    req_valid = 2'b10; req_addr[63:32] = 32'h14; pready = 1'b0; prdata = 32'h7777; #1;
    chk("to_grant", req_ready, 2'b10);
    @(negedge pclk); req_valid = 2'b00;
    for (int i = 0; i < 4; i++) begin
      @(negedge pclk);
      chk("to_access", {psel, penable}, 2'b11);
      chk("to_no_rsp", rsp_valid, 2'b00);
    end
    @(negedge pclk);
    chk("to_psel_off", {psel, penable}, 2'b00);
    chk("to_rsp_valid", rsp_valid, 2'b10);
    chk("to_rsp", {rsp_err, rsp_rdata}, {1'b1, 32'h0});
    req_valid = 2'b01; req_addr[31:0] = 32'h30; pready = 1'b1; prdata = 32'h99; #1;
    chk("to_next_grant", req_ready, 2'b01);
    @(negedge pclk); req_valid = 2'b00;
    chk("to_next_paddr", paddr, 32'h30);
    @(negedge pclk);
    @(negedge pclk);
    chk("to_next_rsp", {rsp_valid, rsp_err, rsp_rdata}, {2'b01, 1'b0, 32'h99});

    // reset during ACCESS drops the transfer and restores the pointer
    req_valid = 2'b01; req_addr[31:0] = 32'h18; pready = 1'b0; #1;
    chk("rst_mid_grant", req_ready, 2'b01);
    @(negedge pclk); req_valid = 2'b10; req_addr[63:32] = 32'h40;
    @(negedge pclk);
    chk("rst_mid_access", {psel, penable}, 2'b11);
    preset_n = 1'b0; #1;
    chk("rst_mid_psel", {psel, penable}, 2'b00);
    chk("rst_mid_rsp", rsp_valid, 2'b00);
    @(negedge pclk);
    @(negedge pclk); preset_n = 1'b1; req_valid = 2'b11; #1;
    chk("rst_after_grant", req_ready, 2'b01);
    chk("rst_after_rsp", rsp_valid, 2'b00);
    @(negedge pclk); req_valid = 2'b10; pready = 1'b1; prdata = 32'h42;
    chk("rst_after_paddr", paddr, 32'h18);
    @(negedge pclk);
    @(negedge pclk); #1;
    chk("rst_after_rsp2", {rsp_valid, rsp_rdata}, {2'b01, 32'h42});
    chk("rst_after_grant1", req_ready, 2'b10);
    req_valid = 2'b00;
    repeat (3) @(negedge pclk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
